// File: rtl/e_mdu_iter.sv
// e_mdu_iter: iterative multiply/divide unit that owns HI/LO and uses a start/busy handshake.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by defining MDU_MADD_EN.
`default_nettype none

module e_mdu_iter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_srcA,
  input  logic [31:0] i_srcB,
  input  logic [4:0]  i_mduOp,
  input  logic        i_start,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic [31:0] o_result
);

  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MFHI  = 5'd5;
  localparam logic [4:0] OP_MFLO  = 5'd6;
  localparam logic [4:0] OP_MTHI  = 5'd7;
  localparam logic [4:0] OP_MTLO  = 5'd8;
`ifdef MDU_MADD_EN
  localparam logic [4:0] OP_MADD  = 5'd9;
  localparam logic [4:0] OP_MADDU = 5'd10;
  localparam logic [4:0] OP_MSUB  = 5'd11;
  localparam logic [4:0] OP_MSUBU = 5'd12;
`endif

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] p_hi_q, p_hi_d;
  logic [31:0] p_lo_q, p_lo_d;
  logic        p_wr_q, p_wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_is_acc;
  logic        w_legal;
  logic        w_sdiv;
  logic [63:0] w_a_sx, w_b_sx;
  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_a_mag, w_b_mag;
  logic [31:0] w_div_a, w_div_b;
  logic [31:0] w_q_u, w_r_u;
  logic [31:0] w_q, w_r;
  logic [63:0] w_res;

  assign w_is_mul = (i_mduOp == OP_MULT) || (i_mduOp == OP_MULTU);
  assign w_is_div = (i_mduOp == OP_DIV)  || (i_mduOp == OP_DIVU);
`ifdef MDU_MADD_EN
  assign w_is_acc = (i_mduOp == OP_MADD) || (i_mduOp == OP_MADDU) ||
                    (i_mduOp == OP_MSUB) || (i_mduOp == OP_MSUBU);
`else
  assign w_is_acc = 1'b0;
`endif
  assign w_legal  = w_is_mul || w_is_div || w_is_acc;

  // Low 64 bits of a 64x64 product of sign-extended operands equal the signed 32x32 product.
  assign w_a_sx   = {{32{i_srcA[31]}}, i_srcA};
  assign w_b_sx   = {{32{i_srcB[31]}}, i_srcB};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {32'd0, i_srcA} * {32'd0, i_srcB};

  // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign w_sdiv  = (i_mduOp == OP_DIV);
  assign w_a_mag = i_srcA[31] ? (32'd0 - i_srcA) : i_srcA;
  assign w_b_mag = i_srcB[31] ? (32'd0 - i_srcB) : i_srcB;
  assign w_div_a = w_sdiv ? w_a_mag : i_srcA;
  assign w_div_b = (i_srcB == 32'd0) ? 32'd1 : (w_sdiv ? w_b_mag : i_srcB);
  assign w_q_u   = w_div_a / w_div_b;
  assign w_r_u   = w_div_a % w_div_b;
  assign w_q     = (w_sdiv && (i_srcA[31] ^ i_srcB[31])) ? (32'd0 - w_q_u) : w_q_u;
  assign w_r     = (w_sdiv && i_srcA[31]) ? (32'd0 - w_r_u) : w_r_u;

  always_comb begin
    w_res = 64'd0;
    case (i_mduOp)
      OP_MULT:  w_res = w_prod_s;
      OP_MULTU: w_res = w_prod_u;
      OP_DIV,
      OP_DIVU:  w_res = {w_r, w_q};
`ifdef MDU_MADD_EN
      OP_MADD:  w_res = {hi_q, lo_q} + w_prod_s;
      OP_MADDU: w_res = {hi_q, lo_q} + w_prod_u;
      OP_MSUB:  w_res = {hi_q, lo_q} - w_prod_s;
      OP_MSUBU: w_res = {hi_q, lo_q} - w_prod_u;
`endif
      default:  w_res = 64'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    p_wr_d  = p_wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (i_start && w_legal) begin
          state_d = S_RUN;
          cnt_d   = w_is_div ? DIV_LOAD : MULT_LOAD;
          p_hi_d  = w_res[63:32];
          p_lo_d  = w_res[31:0];
          // Divide by zero still occupies the unit but leaves HI/LO untouched.
          p_wr_d  = !(w_is_div && (i_srcB == 32'd0));
        end else if (i_mduOp == OP_MTHI) begin
          hi_d = i_srcA;
        end else if (i_mduOp == OP_MTLO) begin
          lo_d = i_srcA;
        end
      end
      S_RUN: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          if (p_wr_q) begin
            hi_d = p_hi_q;
            lo_d = p_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      p_hi_q  <= 32'd0;
      p_lo_q  <= 32'd0;
      p_wr_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      p_wr_q  <= p_wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign o_busy   = (state_q == S_RUN);
  assign o_hi     = hi_q;
  assign o_lo     = lo_q;
  assign o_result = (i_mduOp == OP_MFHI) ? hi_q :
                    (i_mduOp == OP_MFLO) ? lo_q : 32'd0;

endmodule

`default_nettype wire
